// File: rtl/approx_adder_error_monitor.sv
// Exhaustive sweep checker for approximate adders: issues every (A,B) pair and accumulates error statistics.
// Optional watchdog on the WAIT state is compiled in with `define ERRMON_TIMEOUT_EN.
module approx_adder_error_monitor #(
  parameter int W           = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [W-1:0]    op_a,
  output logic [W-1:0]    op_b,
  output logic            op_valid,
  input  logic [W:0]      res,
  input  logic            res_valid,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [2*W:0]    err_count,
  output logic [3*W:0]    err_sum,
  output logic [W:0]      err_max
);

  localparam int CW = 2*W + 1;
  localparam int SW = 3*W + 1;
  localparam int MW = W + 1;

  localparam logic [W-1:0]  OP_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [MW-1:0]   res_q, res_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic [SW-1:0]   err_sum_q, err_sum_d;
  logic [MW-1:0]   err_max_q, err_max_d;

  logic [MW-1:0]   exact;
  logic [MW-1:0]   diff;
  logic            last_pair;

`ifdef ERRMON_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYC - 1);
  localparam logic [WDW-1:0] WDOG_ONE  = {{(WDW-1){1'b0}}, 1'b1};

  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
`endif

  // Error magnitude is unsigned |res - exact|, so both directions of error count alike.
  always_comb begin
    exact     = {1'b0, a_q} + {1'b0, b_q};
    diff      = (res_q >= exact) ? (res_q - exact) : (exact - res_q);
    last_pair = (&a_q) && (&b_q);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    err_count_d = err_count_q;
    err_sum_d   = err_sum_q;
    err_max_d   = err_max_q;
`ifdef ERRMON_TIMEOUT_EN
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_ISSUE;
          a_d         = '0;
          b_d         = '0;
          err_count_d = '0;
          err_sum_d   = '0;
          err_max_d   = '0;
`ifdef ERRMON_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ERRMON_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end

      S_WAIT: begin
        if (res_valid) begin
          res_d   = res;
          state_d = S_CHECK;
        end
`ifdef ERRMON_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
`endif
      end

      // b runs fastest; the carry into a happens when b wraps to zero.
      S_CHECK: begin
        if (diff != '0) begin
          err_count_d = err_count_q + CNT_ONE;
          err_sum_d   = err_sum_q + {{(SW-MW){1'b0}}, diff};
          err_max_d   = (diff > err_max_q) ? diff : err_max_q;
        end
        if (last_pair) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          b_d     = b_q + OP_ONE;
          if (&b_q) begin
            a_d = a_q + OP_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      err_count_q <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      err_count_q <= err_count_d;
      err_sum_q   <= err_sum_d;
      err_max_q   <= err_max_d;
    end
  end

`ifdef ERRMON_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign op_a      = a_q;
  assign op_b      = b_q;
  assign op_valid  = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign err_count = err_count_q;
  assign err_sum   = err_sum_q;
  assign err_max   = err_max_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor at W=4: table-driven sweeps against an adder model with a scoreboard,
// plus hand-written reset-mid-sweep and stalled-adder sequences.
module tb_approx_adder_error_monitor;

  localparam int W    = 4;
  localparam int N    = 1 << W;
  localparam int TCYC = 16;
  localparam int SWEEP_LIMIT = 4000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_valid;
  logic [W:0]     res;
  logic           res_valid;
  logic           busy;
  logic           done;
  logic           timeout;
  logic [2*W:0]   err_count;
  logic [3*W:0]   err_sum;
  logic [W:0]     err_max;

  approx_adder_error_monitor #(.W(W), .TIMEOUT_CYC(TCYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .err_count (err_count),
    .err_sum   (err_sum),
    .err_max   (err_max)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Adder-under-test model and scoreboard state, shared with the responder process.
  int mode      = 0;
  int max_delay = 0;
  bit resp_en   = 1'b1;
  int m_count, m_sum, m_max;
  int pulses, seq_err, stab_err;
  int exp_a, exp_b;

  typedef struct {
    int mode;
    int max_delay;
    bit glitch;
    bit use_model;
    int e_count;
    int e_sum;
    int e_max;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // mode 0 exact, 1 forces S[0]=0, 2 forces Cout=0, 3 random bit flips on some pairs.
  function automatic int adderModel(input int m, input int a, input int b);
    int s;
    s = a + b;
    case (m)
      1: s = s & ~1;
      2: s = s & (N - 1);
      3: if ($urandom_range(0, 3) == 0) s = s ^ int'($urandom_range(1, 2*N - 1));
      default: s = a + b;
    endcase
    return s;
  endfunction

  function automatic vec_t mkVec(input int m, input int dly, input bit gl, input bit um,
                                 input int c, input int s, input int mx);
    vec_t v;
    v.mode = m; v.max_delay = dly; v.glitch = gl; v.use_model = um;
    v.e_count = c; v.e_sum = s; v.e_max = mx;
    return v;
  endfunction

  // Responder: acts as the adder under test and keeps the reference statistics.
  initial begin
    int cap_a, cap_b, rv, ex, d, delay_left, tmp;
    bit pend;
    pend = 1'b0;
    delay_left = 0;
    rv = 0; cap_a = 0; cap_b = 0;
    res_valid = 1'b0;
    res = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (!rst_n || !resp_en) begin
        pend = 1'b0;
      end else if (op_valid) begin
        pulses++;
        if (op_a !== exp_a[W-1:0] || op_b !== exp_b[W-1:0]) seq_err++;
        exp_b++;
        if (exp_b == N) begin
          exp_b = 0;
          exp_a++;
        end
        cap_a = int'(op_a);
        cap_b = int'(op_b);
        rv = adderModel(mode, cap_a, cap_b);
        ex = cap_a + cap_b;
        d  = (rv > ex) ? rv - ex : ex - rv;
        if (d != 0) begin
          m_count++;
          m_sum += d;
          if (d > m_max) m_max = d;
        end
        delay_left = $urandom_range(0, max_delay);
        pend = 1'b1;
      end else if (pend) begin
        if (int'(op_a) != cap_a || int'(op_b) != cap_b) stab_err++;
        if (delay_left == 0) begin
          res = rv[W:0];
          res_valid = 1'b1;
          pend = 1'b0;
        end else begin
          delay_left--;
        end
      end else if (mode == 3 && $urandom_range(0, 1) == 1) begin
        tmp = $urandom;
        res = tmp[W:0];
        res_valid = 1'b1;
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    mode = v.mode;
    max_delay = v.max_delay;
    m_count = 0; m_sum = 0; m_max = 0;
    pulses = 0; seq_err = 0; stab_err = 0;
    exp_a = 0; exp_b = 0;
    pulseStart();
    checkOutput({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    checkOutput({tag, "_done_cleared"}, 64'(done), 64'd0);
    checkOutput({tag, "_count_cleared"}, 64'(err_count), 64'd0);
    checkOutput({tag, "_timeout_cleared"}, 64'(timeout), 64'd0);
    cyc = 0;
    while (!done && cyc < SWEEP_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!done && v.glitch && $urandom_range(0, 15) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    checkOutput({tag, "_sweep_done"}, 64'(done), 64'd1);
    if (v.use_model) begin
      checkOutput({tag, "_err_count"}, 64'(err_count), 64'(m_count));
      checkOutput({tag, "_err_sum"}, 64'(err_sum), 64'(m_sum));
      checkOutput({tag, "_err_max"}, 64'(err_max), 64'(m_max));
    end else begin
      checkOutput({tag, "_err_count"}, 64'(err_count), 64'(v.e_count));
      checkOutput({tag, "_err_sum"}, 64'(err_sum), 64'(v.e_sum));
      checkOutput({tag, "_err_max"}, 64'(err_max), 64'(v.e_max));
    end
    checkOutput({tag, "_op_valid_pulses"}, 64'(pulses), 64'(N*N));
    checkOutput({tag, "_pair_order_errs"}, 64'(seq_err), 64'd0);
    checkOutput({tag, "_operand_stability_errs"}, 64'(stab_err), 64'd0);
    checkOutput({tag, "_timeout_end"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_held"}, 64'(done), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_op_a"}, 64'(op_a), 64'd0);
    checkOutput({tag, "_op_b"}, 64'(op_b), 64'd0);
    checkOutput({tag, "_op_valid"}, 64'(op_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'd0);
    checkOutput({tag, "_err_sum"}, 64'(err_sum), 64'd0);
    checkOutput({tag, "_err_max"}, 64'(err_max), 64'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cyc;
    vecs[0] = mkVec(0, 0, 1'b0, 1'b0, 0,   0,    0);
    vecs[1] = mkVec(1, 0, 1'b0, 1'b0, 128, 128,  1);
    vecs[2] = mkVec(2, 0, 1'b0, 1'b0, 120, 1920, 16);
    vecs[3] = mkVec(2, 5, 1'b1, 1'b0, 120, 1920, 16);
    vecs[4] = mkVec(3, 3, 1'b1, 1'b1, 0,   0,    0);
    vecs[5] = mkVec(0, 2, 1'b0, 1'b0, 0,   0,    0);

    rst_n = 1'b0;
    start = 1'b0;
    #1;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_not_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a sweep, then a clean sweep.
    mode = 1; max_delay = 1;
    m_count = 0; m_sum = 0; m_max = 0; pulses = 0; exp_a = 0; exp_b = 0;
    pulseStart();
    cyc = 0;
    while (pulses < 100 && cyc < SWEEP_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midreset_reached_pair100", 64'(pulses >= 100), 64'd1);
    checkOutput("midreset_stats_nonzero", 64'(err_count != '0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(vecs[1], "after_midreset");

    // Adder never answers.
    resp_en = 1'b0;
    pulseStart();
`ifdef ERRMON_TIMEOUT_EN
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("wdog_cycles_to_done", 64'(cyc), 64'd17);
    checkOutput("wdog_done", 64'(done), 64'd1);
    checkOutput("wdog_timeout", 64'(timeout), 64'd1);
    checkOutput("wdog_err_count", 64'(err_count), 64'd0);
    checkOutput("wdog_busy", 64'(busy), 64'd0);
    resp_en = 1'b1;
    applyStimulus(vecs[2], "restart_after_timeout");
`else
    repeat (40) @(negedge clk);
    checkOutput("stall_busy", 64'(busy), 64'd1);
    checkOutput("stall_done", 64'(done), 64'd0);
    checkOutput("stall_timeout", 64'(timeout), 64'd0);
    checkOutput("stall_op_a", 64'(op_a), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(vecs[2], "restart_after_stall");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
